// File: rtl/pll_drp_pkg.sv
// +----------------------------------------------------------------------+
// | pll_drp_pkg                                                          |
// | Address map, field positions and count helper for pll_drp_regs.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package pll_drp_pkg;

   localparam logic [6:0] ADDR_FIRST    = 7'h06;
   localparam logic [6:0] ADDR_LAST     = 7'h16;
   localparam logic [6:0] ADDR_CLKFB_R1 = 7'h14;
   localparam logic [6:0] ADDR_DIVCLK   = 7'h16;
   localparam int         NUM_REGS      = 17;
   localparam int         NUM_CH        = 8;   // CLKOUT0..6 plus CLKFBOUT

   localparam int R1_MUX_LSB   = 13;
   localparam int R1_HIGH_LSB  = 6;
   localparam int R1_LOW_LSB   = 0;
   localparam int R2_EDGE      = 7;
   localparam int R2_NOCNT     = 6;
   localparam int R2_DELAY_LSB = 0;
   localparam int DIV_NOCNT    = 12;

   // A zero HIGH/LOW count field encodes the full 64-cycle count.
   function automatic logic [6:0] count64(input logic [5:0] v);
      return (v == 6'd0) ? 7'd64 : {1'b0, v};
   endfunction

   function automatic logic [6:0] clkreg1_addr(input int unsigned ch);
      case (ch)
         0:       return 7'h08;
         1:       return 7'h0A;
         2:       return 7'h0C;
         3:       return 7'h0E;
         4:       return 7'h10;
         5:       return 7'h06;
         6:       return 7'h12;
         7:       return ADDR_CLKFB_R1;
         default: return ADDR_DIVCLK;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/drp_clkreg_decode.sv
// +----------------------------------------------------------------------+
// | drp_clkreg_decode                                                    |
// | Decodes one ClkReg1/ClkReg2 pair into divide, duty x1000 and phase.  |
// | Phase arithmetic is built only when PLL_DRP_PHASE_EN is defined.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module drp_clkreg_decode
   import pll_drp_pkg::*;
(
   input  logic [15:0]        reg1_i,
   input  logic [15:0]        reg2_i,
   input  logic               written_i,
   output logic [31:0]        divide_o,
   output logic [31:0]        duty_o,
   output logic signed [31:0] phase_o
);

   logic [6:0]  high;
   logic [6:0]  low;
   logic        edge_bit;
   logic        no_count;
   logic [7:0]  div;
   logic [31:0] div32;
   logic [31:0] duty;
   logic        spare_unused;

   always_comb begin
      high     = count64(reg1_i[R1_HIGH_LSB +: 6]);
      low      = count64(reg1_i[R1_LOW_LSB +: 6]);
      edge_bit = reg2_i[R2_EDGE];
      no_count = reg2_i[R2_NOCNT];
      div      = no_count ? 8'd1 : ({1'b0, high} + {1'b0, low});
      div32    = {24'd0, div};
      duty     = no_count ? 32'd500
                          : (32'd500 * ({24'd0, high, 1'b0} + {31'd0, edge_bit})) / div32;
      divide_o = written_i ? div32 : '0;
      duty_o   = written_i ? duty  : '0;
   end

   assign spare_unused = ^{reg1_i[12], reg2_i[15:8]};

`ifdef PLL_DRP_PHASE_EN
   logic [31:0] taps;

   // 8*DELAY + PHASE_MUX is just the two fields concatenated.
   always_comb begin
      taps    = {23'd0, reg2_i[R2_DELAY_LSB +: 6], reg1_i[R1_MUX_LSB +: 3]};
      phase_o = written_i ? signed'(((taps * 32'd45) / div32) % 32'd360) : '0;
   end
`else
   logic phase_fields_unused;

   assign phase_fields_unused = ^{reg2_i[R2_DELAY_LSB +: 6], reg1_i[R1_MUX_LSB +: 3]};
   assign phase_o             = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/pll_drp_regs.sv
// +----------------------------------------------------------------------+
// | pll_drp_regs                                                         |
// | DRP register block for the PLL/MMCM model with counter decode.       |
// | Optional phase decode: define PLL_DRP_PHASE_EN.                      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module pll_drp_regs
   import pll_drp_pkg::*;
#(
   parameter int DRDY_LATENCY = 2
)
(
   input  logic                dclk_i,
   input  logic                rst_n_i,
   input  logic                pwrdwn_i,
   input  logic [6:0]          daddr_i,
   input  logic                den_i,
   input  logic                dwe_i,
   input  logic [15:0]         di_i,
   output logic [15:0]         do_o,
   output logic                drdy_o,
   output logic [6:0][31:0]    clkout_divide_o,
   output logic [6:0][31:0]    clkout_duty_cycle_1000_o,
   output logic [6:0][31:0]    clkout_phase_o,
   output logic [31:0]         clkfbout_mult_f_1000_o,
   output logic signed [31:0]  clkfbout_phase_o,
   output logic [31:0]         divclk_divide_o
);

   localparam int CW = (DRDY_LATENCY > 1) ? $clog2(DRDY_LATENCY) : 1;

   logic [15:0]        regs_q [NUM_REGS];
   logic [15:0]        regs_d [NUM_REGS];
   logic [NUM_CH:0]    written_q, written_d;   // top bit tracks DIVCLK
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [15:0]        rdata_q, rdata_d;
   logic [15:0]        do_q, do_d;
   logic               drdy_q, drdy_d;
   logic [15:0]        rd_val;
   logic               accept;
   logic               addr_ok;
   logic [4:0]         slot;

   always_comb begin
      addr_ok   = (daddr_i >= ADDR_FIRST) && (daddr_i <= ADDR_LAST);
      slot      = 5'(daddr_i - ADDR_FIRST);
      accept    = den_i && (cnt_q == '0);
      rd_val    = (dwe_i || !addr_ok) ? 16'h0000 : regs_q[slot];
      regs_d    = regs_q;
      written_d = written_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      drdy_d    = 1'b0;
      do_d      = 16'h0000;
      if (accept) begin
         if (dwe_i && addr_ok) begin
            regs_d[slot] = di_i;
            for (int i = 0; i <= NUM_CH; i++) begin
               if (daddr_i == clkreg1_addr(i)) written_d[i] = 1'b1;
            end
         end
         if (DRDY_LATENCY == 1) begin
            drdy_d = 1'b1;
            do_d   = rd_val;
         end else begin
            cnt_d   = CW'(DRDY_LATENCY - 1);
            rdata_d = rd_val;
         end
      end else if (cnt_q != '0) begin
         // Busy: DEN is ignored until the DRDY cycle frees the counter.
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            drdy_d = 1'b1;
            do_d   = rdata_q;
         end
      end
   end

   always_ff @(posedge dclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         regs_q    <= '{default: '0};
         written_q <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         do_q      <= '0;
         drdy_q    <= 1'b0;
      end else if (pwrdwn_i) begin
         regs_q    <= '{default: '0};
         written_q <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         do_q      <= '0;
         drdy_q    <= 1'b0;
      end else begin
         regs_q    <= regs_d;
         written_q <= written_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         do_q      <= do_d;
         drdy_q    <= drdy_d;
      end
   end

   assign do_o   = do_q;
   assign drdy_o = drdy_q;

   logic [31:0]        dec_div   [NUM_CH];
   logic [31:0]        dec_duty  [NUM_CH];
   logic signed [31:0] dec_phase [NUM_CH];
   logic [31:0]        fb_duty_unused;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam int R1 = int'(clkreg1_addr(g)) - int'(ADDR_FIRST);
      drp_clkreg_decode u_dec (
         .reg1_i    (regs_q[R1]),
         .reg2_i    (regs_q[R1 + 1]),
         .written_i (written_q[g]),
         .divide_o  (dec_div[g]),
         .duty_o    (dec_duty[g]),
         .phase_o   (dec_phase[g])
      );
   end

   always_comb begin
      for (int i = 0; i < NUM_CH - 1; i++) begin
         clkout_divide_o[i]          = dec_div[i];
         clkout_duty_cycle_1000_o[i] = dec_duty[i];
         clkout_phase_o[i]           = dec_phase[i];
      end
   end

   assign fb_duty_unused         = dec_duty[NUM_CH-1];
   assign clkfbout_mult_f_1000_o = dec_div[NUM_CH-1] * 32'd1000;
   assign clkfbout_phase_o       = dec_phase[NUM_CH-1];

   logic [15:0] divclk_reg;
   logic [7:0]  divclk_cnt;

   always_comb begin
      divclk_reg      = regs_q[NUM_REGS-1];
      divclk_cnt      = divclk_reg[DIV_NOCNT] ? 8'd1
                        : ({1'b0, count64(divclk_reg[R1_HIGH_LSB +: 6])}
                           + {1'b0, count64(divclk_reg[R1_LOW_LSB +: 6])});
      divclk_divide_o = written_q[NUM_CH] ? {24'd0, divclk_cnt} : '0;
   end

endmodule

`default_nettype wire

// File: tb/tb_pll_drp_regs.sv
// +----------------------------------------------------------------------+
// | tb_pll_drp_regs                                                      |
// | Directed plus randomized DRP traffic against an arithmetic model.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pll_drp_regs;

   localparam int LAT = 2;

   logic               clk = 1'b0;
   logic               rst_n, pwrdwn, den, dwe;
   logic [6:0]         daddr;
   logic [15:0]        di, do_w;
   logic               drdy;
   logic [6:0][31:0]   div_o, duty_o, ph_o;
   logic [31:0]        fbm, divc;
   logic signed [31:0] fbph;

   always #5 clk = ~clk;

   pll_drp_regs #(.DRDY_LATENCY(LAT)) dut (
      .dclk_i                   (clk),
      .rst_n_i                  (rst_n),
      .pwrdwn_i                 (pwrdwn),
      .daddr_i                  (daddr),
      .den_i                    (den),
      .dwe_i                    (dwe),
      .di_i                     (di),
      .do_o                     (do_w),
      .drdy_o                   (drdy),
      .clkout_divide_o          (div_o),
      .clkout_duty_cycle_1000_o (duty_o),
      .clkout_phase_o           (ph_o),
      .clkfbout_mult_f_1000_o   (fbm),
      .clkfbout_phase_o         (fbph),
      .divclk_divide_o          (divc)
   );

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] mreg [128];
   bit          mwr [9];
   int unsigned R1A [9] = '{8, 10, 12, 14, 16, 6, 18, 20, 22};
   logic [15:0] last_do;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      foreach (mreg[i]) mreg[i] = 16'h0000;
      foreach (mwr[i]) mwr[i] = 1'b0;
   endfunction

   function automatic bit valid(input int a);
      return (a >= 6) && (a <= 22);
   endfunction

   function automatic void model_write(input int a, input logic [15:0] d);
      if (valid(a)) begin
         mreg[a] = d;
         for (int c = 0; c < 9; c++) if (R1A[c] == a) mwr[c] = 1'b1;
      end
   endfunction

   function automatic int cnt64(input int v);
      return (v == 0) ? 64 : v;
   endfunction

   function automatic void decode(input logic [15:0] r1, input logic [15:0] r2,
                                  output int d, output int duty, output int ph);
      int h, l;
      h    = cnt64(int'(r1[11:6]));
      l    = cnt64(int'(r1[5:0]));
      d    = r2[6] ? 1 : h + l;
      duty = r2[6] ? 500 : (500 * (2 * h + int'(r2[7]))) / d;
`ifdef PLL_DRP_PHASE_EN
      ph   = ((8 * int'(r2[5:0]) + int'(r1[15:13])) * 45 / d) % 360;
`else
      ph   = 0;
`endif
   endfunction

   task automatic check_all(input string tag);
      int d, du, p;
      for (int c = 0; c < 7; c++) begin
         decode(mreg[R1A[c]], mreg[R1A[c] + 1], d, du, p);
         if (!mwr[c]) begin d = 0; du = 0; p = 0; end
         chk($sformatf("%s div%0d", tag, c), div_o[c], d);
         chk($sformatf("%s duty%0d", tag, c), duty_o[c], du);
         chk($sformatf("%s phase%0d", tag, c), ph_o[c], p);
      end
      decode(mreg[20], mreg[21], d, du, p);
      if (!mwr[7]) begin d = 0; p = 0; end
      chk($sformatf("%s fbmult", tag), fbm, d * 1000);
      chk($sformatf("%s fbphase", tag), fbph, p);
      d = mreg[22][12] ? 1 : cnt64(int'(mreg[22][11:6])) + cnt64(int'(mreg[22][5:0]));
      if (!mwr[8]) d = 0;
      chk($sformatf("%s divclk", tag), divc, d);
   endtask

   // One transaction; with dup set, DEN is held a second cycle with other write data.
   task automatic txn(input logic [6:0] a, input bit we, input logic [15:0] d, input bit dup);
      logic [15:0] exp_do;
      exp_do = (we || !valid(int'(a))) ? 16'h0000 : mreg[a];
      @(negedge clk);
      daddr = a; dwe = we; di = d; den = 1'b1;
      if (we) model_write(int'(a), d);
      for (int n = 1; n <= LAT + 2; n++) begin
         @(negedge clk);
         chk($sformatf("drdy n=%0d a=%0h", n, a), {31'd0, drdy}, {31'd0, n == LAT});
         if (n == LAT) begin
            last_do = do_w;
            chk($sformatf("do a=%0h", a), do_w, exp_do);
         end else begin
            chk($sformatf("do idle n=%0d", n), do_w, 0);
         end
         if (n == 1 && dup) begin
            dwe = 1'b1; di = ~d;
         end else begin
            den = 1'b0;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; pwrdwn = 1'b0; den = 1'b0; dwe = 1'b0; daddr = '0; di = '0;
      last_do = '0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("reset drdy", {31'd0, drdy}, 0);
      chk("reset do", do_w, 0);
      check_all("reset");
      rst_n = 1'b1;

      txn(7'h08, 1, 16'h0145, 0);
      txn(7'h09, 1, 16'h0000, 0);
      chk("even div", div_o[0], 10);
      chk("even duty", duty_o[0], 500);
      chk("even phase", ph_o[0], 0);
      check_all("even");

      txn(7'h0A, 1, 16'h0083, 0);
      txn(7'h0B, 1, 16'h0080, 0);
      chk("odd div", div_o[1], 5);
      chk("odd duty edge", duty_o[1], 500);
      txn(7'h0B, 1, 16'h0000, 0);
      chk("odd duty noedge", duty_o[1], 400);
      check_all("odd");

      txn(7'h0C, 1, 16'h8104, 0);
      txn(7'h0D, 1, 16'h0001, 0);
      chk("ph div", div_o[2], 8);
`ifdef PLL_DRP_PHASE_EN
      chk("ph phase", ph_o[2], 67);
`else
      chk("ph phase", ph_o[2], 0);
`endif
      txn(7'h0C, 0, 16'h0000, 0);
      chk("readback 0C", last_do, 16'h8104);
      txn(7'h30, 0, 16'h0000, 0);
      chk("readback 30", last_do, 16'h0000);

      txn(7'h14, 1, 16'h0104, 0);
      chk("fb mult", fbm, 8000);
      txn(7'h16, 1, 16'h1000, 0);
      chk("divclk nocount", divc, 1);
      check_all("fb_divclk");

      txn(7'h0E, 1, 16'h0042, 1);
      check_all("busy");

      // DEN raised in the DRDY cycle starts the next transaction.
      @(negedge clk);
      daddr = 7'h10; dwe = 1'b1; di = 16'h0208; den = 1'b1;
      model_write(16, 16'h0208);
      @(negedge clk); den = 1'b0;
      @(negedge clk);
      chk("chain drdy1", {31'd0, drdy}, 1);
      daddr = 7'h11; di = 16'h00C0; den = 1'b1;
      model_write(17, 16'h00C0);
      @(negedge clk); den = 1'b0;
      chk("chain gap", {31'd0, drdy}, 0);
      @(negedge clk);
      chk("chain drdy2", {31'd0, drdy}, 1);
      check_all("chain");

      for (int t = 0; t < 60; t++) begin
         logic [6:0] a;
         a = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(6, 22));
         txn(a, $urandom_range(0, 2) != 0, 16'($urandom), 0);
         check_all($sformatf("rand%0d", t));
         if (t == 30) begin
            @(negedge clk); pwrdwn = 1'b1;
            @(negedge clk); pwrdwn = 1'b0;
            model_clear();
            chk("pwrdwn drdy", {31'd0, drdy}, 0);
            check_all("pwrdwn");
         end
      end

      @(negedge clk);
      daddr = 7'h08; dwe = 1'b1; di = 16'h0145; den = 1'b1;
      @(negedge clk); den = 1'b0; rst_n = 1'b0;
      model_clear();
      @(negedge clk); rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         chk($sformatf("rst_mid drdy %0d", n), {31'd0, drdy}, 0);
      end
      check_all("rst_mid");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
